// File: rtl/minimig_autoconfig_master.sv
// Host-side AutoConfig enumerator: reads each board's type/flags, places it
// in the ZII RAM / ZII I/O / ZIII window and writes its base or shuts it up.
module minimig_autoconfig_master #(
    parameter int          MAX_BOARDS   = 6,
    parameter int          TIMEOUT      = 255,
    parameter logic [7:0]  Z2_MEM_BASE  = 8'h20,
    parameter logic [7:0]  Z2_MEM_LIMIT = 8'hA0,
    parameter logic [7:0]  Z2_IO_BASE   = 8'hE9,
    parameter logic [7:0]  Z2_IO_LIMIT  = 8'hF0,
    parameter logic [15:0] Z3_BASE      = 16'h4000,
    parameter logic [15:0] Z3_LIMIT     = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        start,
    output logic        bus_req,
    output logic [7:0]  bus_addr,
    output logic        bus_rd,
    output logic        bus_hwr,
    output logic        bus_lwr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    input  logic        bus_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  boards_found,
    output logic [7:0]  z2_mem_top,
    output logic [15:0] z3_top
);

    localparam int         TW     = $clog2(TIMEOUT + 1);
    localparam logic [3:0] MAXB   = 4'(MAX_BOARDS);
    localparam logic [7:0] A_Z3   = 8'h22;
    localparam logic [7:0] A_Z2   = 8'h24;
    localparam logic [7:0] A_SHUT = 8'h26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EVAL,
        S_WR_BASE,
        S_SHUTUP,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]    rd_idx, rd_idx_nx;
    logic [7:0]    type_q, type_nx;
    logic [7:0]    flags_q, flags_nx;
    logic [3:0]    count, count_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [7:0]    io_ptr, io_ptr_nx;
    logic [7:0]    mem_top_nx;
    logic [15:0]   z3_top_nx;
    logic [7:0]    wr_addr, wr_addr_nx;
    logic [15:0]   wr_data, wr_data_nx;
    logic          req_nx, rd_nx, hwr_nx, lwr_nx;
    logic [7:0]    addr_nx;
    logic [15:0]   dout_nx;
    logic          done_nx, error_nx;
    logic [2:0]    found_nx;
    logic [3:0]    nib;

    // ZII allocation, one bit wider than needed so the fit test cannot wrap
    logic [8:0]  z2_size;
    logic [7:0]  z2_ptr, z2_lim;
    logic [9:0]  z2_base, z2_end;
    logic        z2_fit;

    always_comb begin
        z2_size = 9'd128;
        if (type_q[2:0] != 3'd0)
            z2_size = 9'd1 << (type_q[2:0] - 3'd1);
    end

    assign z2_ptr  = type_q[5] ? z2_mem_top : io_ptr;
    assign z2_lim  = type_q[5] ? Z2_MEM_LIMIT : Z2_IO_LIMIT;
    assign z2_base = ({2'b00, z2_ptr} + {1'b0, z2_size} - 10'd1)
                   & ~({1'b0, z2_size} - 10'd1);
    assign z2_end  = z2_base + {1'b0, z2_size};
    assign z2_fit  = z2_end <= {2'b00, z2_lim};

    logic [16:0] z3_size;
    logic [17:0] z3_base, z3_end;
    logic        z3_ok, z3_fit;

    always_comb begin
        case (type_q[2:0])
            3'd0:    z3_size = 17'd256;
            3'd1:    z3_size = 17'd512;
            3'd2:    z3_size = 17'd1024;
            default: z3_size = 17'd0;
        endcase
    end

    assign z3_ok   = !flags_q[5] && (type_q[2:0] <= 3'd2);
    assign z3_base = ({2'b00, z3_top} + {1'b0, z3_size} - 18'd1)
                   & ~({1'b0, z3_size} - 18'd1);
    assign z3_end  = z3_base + {1'b0, z3_size};
    assign z3_fit  = z3_end <= {2'b00, Z3_LIMIT};

    assign nib  = bus_din[15:12];
    assign busy = (state != S_IDLE) && (state != S_DONE);

    logic unused_bits;
    assign unused_bits = ^{bus_din[11:0], type_q[4:3], flags_q[7:6],
                           flags_q[4:0], z2_base[9:8], z3_base[17:16]};

    always_comb begin
        state_nx   = state;
        rd_idx_nx  = rd_idx;
        type_nx    = type_q;
        flags_nx   = flags_q;
        count_nx   = count;
        tmo_nx     = tmo;
        io_ptr_nx  = io_ptr;
        mem_top_nx = z2_mem_top;
        z3_top_nx  = z3_top;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
        req_nx     = bus_req;
        rd_nx      = bus_rd;
        hwr_nx     = bus_hwr;
        lwr_nx     = bus_lwr;
        addr_nx    = bus_addr;
        dout_nx    = bus_dout;
        done_nx    = done;
        error_nx   = error;
        found_nx   = boards_found;

        if (clk7_en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done_nx    = 1'b0;
                        error_nx   = 1'b0;
                        found_nx   = 3'd0;
                        mem_top_nx = Z2_MEM_BASE;
                        io_ptr_nx  = Z2_IO_BASE;
                        z3_top_nx  = Z3_BASE;
                        count_nx   = 4'd0;
                        rd_idx_nx  = 2'd0;
                        state_nx   = S_RD;
                    end
                end
                S_RD, S_WR_BASE, S_SHUTUP: begin
                    if (!bus_req) begin
                        req_nx = 1'b1;
                        tmo_nx = TW'(TIMEOUT);
                        if (state == S_RD) begin
                            rd_nx   = 1'b1;
                            addr_nx = {5'd0, rd_idx[1], 1'b0, rd_idx[0]};
                        end else begin
                            hwr_nx  = 1'b1;
                            lwr_nx  = 1'b1;
                            addr_nx = (state == S_SHUTUP) ? A_SHUT : wr_addr;
                            dout_nx = (state == S_SHUTUP) ? 16'h0000 : wr_data;
                        end
                    end else if (bus_ack) begin
                        req_nx  = 1'b0;
                        rd_nx   = 1'b0;
                        hwr_nx  = 1'b0;
                        lwr_nx  = 1'b0;
                        addr_nx = 8'h00;
                        dout_nx = 16'h0000;
                        if (state == S_RD) begin
                            case (rd_idx)
                                2'd0:    type_nx[7:4]  = nib;
                                2'd1:    type_nx[3:0]  = nib;
                                2'd2:    flags_nx[7:4] = ~nib;
                                default: flags_nx[3:0] = ~nib;
                            endcase
                            rd_idx_nx = rd_idx + 2'd1;
                            if (rd_idx == 2'd3)
                                state_nx = S_EVAL;
                        end else begin
                            count_nx  = count + 4'd1;
                            rd_idx_nx = 2'd0;
                            if (count_nx == MAXB) begin
                                state_nx = S_DONE;
                                done_nx  = 1'b1;
                            end else begin
                                state_nx = S_RD;
                            end
                        end
                    end else if (tmo == TW'(1)) begin
                        req_nx   = 1'b0;
                        rd_nx    = 1'b0;
                        hwr_nx   = 1'b0;
                        lwr_nx   = 1'b0;
                        addr_nx  = 8'h00;
                        dout_nx  = 16'h0000;
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        error_nx = 1'b1;
                    end else begin
                        tmo_nx = tmo - TW'(1);
                    end
                end
                S_EVAL: begin
                    if (type_q[7:6] == 2'b11 && z2_fit) begin
                        state_nx   = S_WR_BASE;
                        wr_addr_nx = A_Z2;
                        wr_data_nx = {z2_base[7:0], z2_base[7:0]};
                        if (type_q[5])
                            mem_top_nx = z2_end[7:0];
                        else
                            io_ptr_nx = z2_end[7:0];
                        if (boards_found != 3'd7)
                            found_nx = boards_found + 3'd1;
                    end else if (type_q[7:6] == 2'b10 && z3_ok && z3_fit) begin
                        state_nx   = S_WR_BASE;
                        wr_addr_nx = A_Z3;
                        wr_data_nx = z3_base[15:0];
                        z3_top_nx  = z3_end[15:0];
                        if (boards_found != 3'd7)
                            found_nx = boards_found + 3'd1;
                    end else if (type_q[7]) begin
                        state_nx = S_SHUTUP;
                    end else begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            rd_idx       <= 2'd0;
            type_q       <= 8'h00;
            flags_q      <= 8'h00;
            count        <= 4'd0;
            tmo          <= '0;
            io_ptr       <= Z2_IO_BASE;
            z2_mem_top   <= Z2_MEM_BASE;
            z3_top       <= Z3_BASE;
            wr_addr      <= 8'h00;
            wr_data      <= 16'h0000;
            bus_req      <= 1'b0;
            bus_rd       <= 1'b0;
            bus_hwr      <= 1'b0;
            bus_lwr      <= 1'b0;
            bus_addr     <= 8'h00;
            bus_dout     <= 16'h0000;
            done         <= 1'b0;
            error        <= 1'b0;
            boards_found <= 3'd0;
        end else begin
            state        <= state_nx;
            rd_idx       <= rd_idx_nx;
            type_q       <= type_nx;
            flags_q      <= flags_nx;
            count        <= count_nx;
            tmo          <= tmo_nx;
            io_ptr       <= io_ptr_nx;
            z2_mem_top   <= mem_top_nx;
            z3_top       <= z3_top_nx;
            wr_addr      <= wr_addr_nx;
            wr_data      <= wr_data_nx;
            bus_req      <= req_nx;
            bus_rd       <= rd_nx;
            bus_hwr      <= hwr_nx;
            bus_lwr      <= lwr_nx;
            bus_addr     <= addr_nx;
            bus_dout     <= dout_nx;
            done         <= done_nx;
            error        <= error_nx;
            boards_found <= found_nx;
        end
    end

endmodule

// File: tb/tb_minimig_autoconfig_master.sv
// Directed bench for the AutoConfig enumerator: the bench plays the board
// chain on the config bus and checks every write and the final pointers.
module tb_minimig_autoconfig_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic        start;
    logic        bus_req;
    logic [7:0]  bus_addr;
    logic        bus_rd;
    logic        bus_hwr;
    logic        bus_lwr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_ack;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  boards_found;
    logic [7:0]  z2_mem_top;
    logic [15:0] z3_top;

    int n_checks = 0;
    int n_fail   = 0;

    minimig_autoconfig_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk7_en      (clk7_en),
        .start        (start),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_rd       (bus_rd),
        .bus_hwr      (bus_hwr),
        .bus_lwr      (bus_lwr),
        .bus_dout     (bus_dout),
        .bus_din      (bus_din),
        .bus_ack      (bus_ack),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .boards_found (boards_found),
        .z2_mem_top   (z2_mem_top),
        .z3_top       (z3_top)
    );

    always #5 clk = ~clk;

    // one clk7_en tick every fourth clock, changed just after the rising edge
    initial begin
        int cnt;
        cnt = 0;
        clk7_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            clk7_en = (cnt % 4 == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        while (!clk7_en) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ack_now(input logic [3:0] nib);
        while (!clk7_en) @(negedge clk);
        bus_din = {nib, 12'h000};
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_din = 16'h0000;
    endtask

    task automatic serve_rd(input logic [7:0] addr, input logic [3:0] nib);
        int n;
        n = 0;
        while (!(bus_req && bus_rd) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("rd_wait", 32'(n < 4000), 1);
        chk("rd_addr", bus_addr, addr);
        ack_now(nib);
    endtask

    task automatic serve_wr(input logic [7:0] addr, input logic [15:0] data);
        int n;
        n = 0;
        while (!(bus_req && !bus_rd) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("wr_wait", 32'(n < 4000), 1);
        chk("wr_addr", bus_addr, addr);
        chk("wr_data", bus_dout, data);
        chk("wr_strb", {bus_hwr, bus_lwr}, 2'b11);
        ack_now(4'h0);
    endtask

    task automatic board(input logic [7:0] typ, input logic [7:0] flg_raw);
        serve_rd(8'h00, typ[7:4]);
        serve_rd(8'h01, typ[3:0]);
        serve_rd(8'h04, flg_raw[7:4]);
        serve_rd(8'h05, flg_raw[3:0]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", 32'(n < 4000), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        bus_din = 16'h0000;
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_found", boards_found, 0);
        chk("rst_z2top", z2_mem_top, 8'h20);
        chk("rst_z3top", z3_top, 16'h4000);
        chk("rst_dout", bus_dout, 0);
        reset_n = 1'b1;

        // 2M ZII RAM then terminator
        pulse_start();
        chk("s1_busy", busy, 1);
        board(8'hE6, 8'hFF);
        serve_wr(8'h24, 16'h2020);
        board(8'h00, 8'hFF);
        wait_done();
        chk("s1_err", error, 0);
        chk("s1_busy_end", busy, 0);
        chk("s1_found", boards_found, 1);
        chk("s1_z2top", z2_mem_top, 8'h40);

        // 2M then 8M: the 8M board no longer fits
        pulse_start();
        board(8'hE6, 8'hFF);
        serve_wr(8'h24, 16'h2020);
        board(8'hE0, 8'hFF);
        serve_wr(8'h26, 16'h0000);
        board(8'h00, 8'hFF);
        wait_done();
        chk("s2_found", boards_found, 1);
        chk("s2_z2top", z2_mem_top, 8'h40);

        // ZIII 16M, 64M, then an unsupported size code
        pulse_start();
        board(8'h80, 8'hFF);
        serve_wr(8'h22, 16'h4000);
        chk("s3_z3top_a", z3_top, 16'h4100);
        board(8'h82, 8'hFF);
        serve_wr(8'h22, 16'h4400);
        board(8'h84, 8'hFF);
        serve_wr(8'h26, 16'h0000);
        board(8'h00, 8'hFF);
        wait_done();
        chk("s3_found", boards_found, 2);
        chk("s3_z3top", z3_top, 16'h4800);
        chk("s3_z2top", z2_mem_top, 8'h20);

        // ZII I/O: 64K at $E9, 256K at $EC, then the window is full
        pulse_start();
        board(8'hC1, 8'hFF);
        serve_wr(8'h24, 16'hE9E9);
        board(8'hC3, 8'hFF);
        serve_wr(8'h24, 16'hECEC);
        board(8'hC1, 8'hFF);
        serve_wr(8'h26, 16'h0000);
        board(8'h00, 8'hFF);
        wait_done();
        chk("s4_found", boards_found, 2);
        chk("s4_err", error, 0);

        // no ack on RD(1): abort after the timeout
        pulse_start();
        serve_rd(8'h00, 4'hC);
        begin
            int n;
            n = 0;
            while (!bus_req && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("s5_rd1_addr", bus_addr, 8'h01);
        wait_done();
        chk("s5_req", bus_req, 0);
        chk("s5_done", done, 1);
        chk("s5_err", error, 1);

        // restart after the abort
        pulse_start();
        chk("s5r_done", done, 0);
        chk("s5r_err", error, 0);
        chk("s5r_busy", busy, 1);
        board(8'hC1, 8'hFF);
        serve_wr(8'h24, 16'hE9E9);
        board(8'h00, 8'hFF);
        wait_done();
        chk("s5r_err_end", error, 0);
        chk("s5r_found", boards_found, 1);

        // seven 64K boards: only six are serviced
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'hE9 + 8'(i);
            board(8'hC1, 8'hFF);
            serve_wr(8'h24, {b, b});
        end
        wait_done();
        chk("s6_found", boards_found, 6);
        repeat (20) @(negedge clk);
        chk("s6_no_rd", bus_req, 0);
        chk("s6_done", done, 1);

        // reset while a base write is pending
        pulse_start();
        board(8'hE6, 8'hFF);
        begin
            int n;
            n = 0;
            while (!bus_req && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("s7_wr_pend", {bus_req, bus_hwr}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("s7_req", bus_req, 0);
        chk("s7_busy", busy, 0);
        chk("s7_found", boards_found, 0);
        chk("s7_z2top", z2_mem_top, 8'h20);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("s7_idle_req", bus_req, 0);
        chk("s7_idle_busy", busy, 0);
        chk("s7_idle_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
